// File: rtl/priority_scan_encoder.sv
// Captures a request vector on load, then hands out the index of each set bit
// in priority order, one per valid/ready transfer, with a done pulse per vector.
module priority_scan_encoder #(
   parameter int unsigned N         = 8,
   parameter int unsigned IDX_W     = 3,
   parameter bit          MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             load,
   input  logic [N-1:0]     inp,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out,
   output logic             out_last,
   output logic             busy,
   output logic             done,
   output logic [IDX_W:0]   emitted
);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [N-1:0]     r_pending;
   logic [N-1:0]     w_pending_nxt;
   logic [IDX_W:0]   r_emitted;
   logic [IDX_W:0]   w_emitted_nxt;
   logic             r_done;
   logic             w_done_nxt;
   logic [IDX_W-1:0] w_idx;
   logic             w_onehot;
   logic [N-1:0]     w_clr;
   logic             w_active;
   logic             w_xfer;

   // Last hit in the loop wins, so loop direction selects the priority.
   always_comb begin
      w_idx = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (MSB_FIRST) begin
            if (r_pending[i]) w_idx = IDX_W'(i);
         end else begin
            if (r_pending[N-1-i]) w_idx = IDX_W'(N-1-i);
         end
      end
   end

   always_comb begin
      w_clr        = '0;
      w_clr[w_idx] = 1'b1;
   end

   assign w_onehot = (r_pending != '0) && ((r_pending & (r_pending - 1'b1)) == '0);
   assign w_active = (r_state == SCAN) && en;
   assign w_xfer   = w_active && out_ready;

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      w_emitted_nxt = r_emitted;
      w_done_nxt    = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (en && load) begin
               w_pending_nxt = inp;
               w_emitted_nxt = '0;
               if (inp != '0) w_state_nxt = SCAN;
               else           w_done_nxt  = 1'b1;
            end
         end
         SCAN: begin
            if (w_xfer) begin
               w_pending_nxt = r_pending & ~w_clr;
               w_emitted_nxt = r_emitted + (IDX_W+1)'(1);
               if (w_onehot) begin
                  w_state_nxt = IDLE;
                  w_done_nxt  = 1'b1;
               end
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_emitted <= '0;
         r_done    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pending <= w_pending_nxt;
         r_emitted <= w_emitted_nxt;
         r_done    <= w_done_nxt;
      end
   end

   assign out_valid = w_active;
   assign out       = w_active ? w_idx : '0;
   assign out_last  = w_active && w_onehot;
   assign busy      = (r_state == SCAN);
   assign done      = r_done;
   assign emitted   = r_emitted;

endmodule
